pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage RV32I pipeline. It owns the IF/ID/EX/MEM pipeline-register enables, inserts bubbles, and drives the PC-source select.
- Combines load-use interlock, taken-branch flush, data-memory wait and an ecall/mret drain-then-redirect FSM into one prioritized control set.
- Inputs come from the decode outputs of the ID stage and from EX/MEM status.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN so older instructions and the mret/ecall retire (legal range 1..7).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_is_mret  in  1  ID instruction is mret.
- id_is_ecall  in  1  ID instruction is ecall.
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_wr_reg_n  in  1  0 = EX writes rd.
- ex_br_taken  in  1  branch/jal/jalr resolved taken in EX.
- mem_req  in  1  MEM stage accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold ID/EX input side (ID instruction retained).
- stall_ex  out  1  hold EX/MEM.
- stall_mem  out  1  hold MEM/WB.
- flush_id  out  1  clear IF/ID to a bubble.
- bubble_ex  out  1  load a bubble into ID/EX.
- pc_sel  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = trap vector (mtvec), 11 = mepc.
- stall_count  out  CNT_W  cycles with stall_if=1, saturating.

Behaviour:
- All outputs are combinational from the current state and inputs. Only state, drain_cnt, kind and stall_count are registered.
- Reset, and whenever rst_n=0: state=RUN, drain_cnt=0, kind=0, stall_count=0. All stall/flush/bubble outputs read 0 and pc_sel=00.
- States:
  - RUN: normal operation.
  - DRAIN: waiting for older instructions to retire; counts with drain_cnt.
  - REDIRECT: one-cycle PC redirect.
- kind register: 1 = mret, 0 = ecall.
- Signal definitions:
  - memwait = mem_req & ~mem_ready.
  - loaduse = ex_valid & ex_is_load & ~ex_wr_reg_n & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority, highest first: memwait > REDIRECT > ex_br_taken > DRAIN entry > loaduse.
- memwait, any state: stall_if=stall_id=stall_ex=stall_mem=1, no flush, no bubble, pc_sel=00. State, drain_cnt and kind are frozen. A pending branch or redirect is deferred, not lost.
- RUN with ex_br_taken: pc_sel=01, flush_id=1, bubble_ex=1. The concurrent loaduse and DRAIN entry are suppressed because the ID instruction is wrong-path.
- RUN, id_valid & (id_is_mret | id_is_ecall), no branch:
  - Move to DRAIN, set drain_cnt=DRAIN_CYCLES-1, set kind=id_is_mret.
  - This cycle: stall_if=1, flush_id=1. The mret/ecall itself advances into EX.
- RUN with loaduse only: stall_if=stall_id=1, bubble_ex=1 for exactly one cycle. It releases once the load leaves EX.
- DRAIN:
  - stall_if=1, flush_id=1, bubble_ex=1.
  - drain_cnt decrements each non-memwait cycle.
  - When drain_cnt==0 (and no memwait), move to REDIRECT.
  - ex_br_taken is ignored in DRAIN; the EX content is a bubble or the mret/ecall.
- REDIRECT: pc_sel = kind ? 11 : 10, flush_id=1, bubble_ex=1, then RUN. IF fetches the target in the next cycle.
- DRAIN_CYCLES=1: DRAIN lasts one cycle.
- stall_count increments on each clock edge with stall_if=1 and holds at all-ones.
- Reset mid-DRAIN or mid-REDIRECT aborts to RUN immediately, with no redirect.

Decomposition:
- Shared header ctrl_defs.vh holds:
  - PC_SEL_SEQ/BR/TRAP/MEPC codes.
  - FSM state codes: RUN=2'd0, DRAIN=2'd1, REDIRECT=2'd2.
- One combinational sub-module, hazard_detect: computes loaduse from the ID and EX fields.
- The FSM, priority logic and counter stay in pipeline_ctrl.

Test Plan:
- Load-use:
  - Stimulus: ex lw x5 (ex_rd=5, ex_is_load=1, ex_wr_reg_n=0); ID add using rs1=5.
  - Response: one cycle of stall_if=stall_id=bubble_ex=1, stall_count 0→1.
  - Repeat with ex_rd=0: no stall.
- Branch vs load-use:
  - Stimulus: ex_br_taken=1 with the loaduse condition true.
  - Response: pc_sel=01, flush_id=1, bubble_ex=1, stall_id=0.
- mret:
  - Stimulus: id_is_mret with DRAIN_CYCLES=3.
  - Response: one RUN cycle with flush_id=1, then 3 DRAIN cycles with stall_if=1, then one REDIRECT cycle with pc_sel=11, then RUN.
  - An ecall gives the same sequence with pc_sel=10.
- Memory wait inside DRAIN:
  - Stimulus: mem_req=1, mem_ready=0 for 4 cycles during DRAIN cycle 2.
  - Response: all four stalls asserted, drain_cnt frozen, total DRAIN length = 3+4 cycles.
- Reset and saturation:
  - Stimulus: rst_n low during REDIRECT.
  - Response: outputs 0 and pc_sel=00 immediately; RUN after release.
  - Stimulus: CNT_W=4 with continuous stall.
  - Response: stall_count saturates at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state codes, PC-source
// select codes and the debug view of the sequencer's registered state.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SEL_BR   = 2'b01;  // branch / jump target
    localparam logic [1:0] PC_SEL_TRAP = 2'b10;  // mtvec
    localparam logic [1:0] PC_SEL_MEPC = 2'b11;  // mepc

    // Registered sequencer state, exported for observation.
    typedef struct packed {
        state_t     state;
        logic [2:0] drain_cnt;
        logic       kind;       // 1 = mret, 0 = ecall
    } dbg_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector. Flags when the instruction in ID reads a register
// that the load currently in EX will write, so the consumer must wait a cycle.
// Ports:
//   id_*_i   decode fields of the ID-stage instruction
//   ex_*_i   fields of the EX-stage instruction
//   loaduse_o  1 = ID must stall behind the EX load
module hazard_detect (
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic       ex_valid_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_wr_reg_n_i,
    output logic       loaduse_o
);

    logic ex_load_wr;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real dependency.
    assign ex_load_wr = ex_valid_i & ex_is_load_i & ~ex_wr_reg_n_i & (ex_rd_i != 5'd0);
    assign rs1_hit    = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
    assign loaduse_o  = ex_load_wr & id_valid_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage RV32I pipeline. Drives pipeline-register
// holds, flushes, bubbles and the PC-source select from one prioritized set:
//   memwait > REDIRECT > taken branch > trap drain entry > load-use.
// ecall/mret enter DRAIN for DRAIN_CYCLES cycles so older work retires, then a
// single REDIRECT cycle steers the PC to mtvec (ecall) or mepc (mret).
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   id_*                  ID-stage decode information
//   ex_*                  EX-stage status (load, destination, branch taken)
//   mem_req, mem_ready    data-memory handshake; a request completes when both
//                         are high, and while mem_req=1 & mem_ready=0 the whole
//                         pipeline holds
//   stall_* / flush_id / bubble_ex / pc_sel   combinational control outputs
//   stall_count           saturating count of cycles with stall_if=1
//   dbg_o                 registered FSM state, drain counter and kind
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_is_mret,
    input  logic             id_is_ecall,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wr_reg_n,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] stall_count,
    output dbg_t             dbg_o
);

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       drain_cnt_q, drain_cnt_d;
    logic             kind_q, kind_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic       loaduse;
    logic       memwait;
    logic       trap_in_id;
    logic       stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
    logic       flush_id_c, bubble_ex_c;
    logic [1:0] pc_sel_c;

    hazard_detect u_hazard (
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_valid_i    (ex_valid),
        .ex_is_load_i  (ex_is_load),
        .ex_rd_i       (ex_rd),
        .ex_wr_reg_n_i (ex_wr_reg_n),
        .loaduse_o     (loaduse)
    );

    assign memwait    = mem_req & ~mem_ready;
    assign trap_in_id = id_valid & (id_is_mret | id_is_ecall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= 3'd0;
            kind_q        <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            kind_q        <= kind_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        kind_d      = kind_q;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        stall_mem_c = 1'b0;
        flush_id_c  = 1'b0;
        bubble_ex_c = 1'b0;
        pc_sel_c    = PC_SEL_SEQ;

        if (memwait) begin
            // Whole pipeline frozen; any pending redirect or branch is
            // simply re-evaluated once memory completes.
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            stall_ex_c  = 1'b1;
            stall_mem_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_REDIRECT: begin
                    pc_sel_c    = kind_q ? PC_SEL_MEPC : PC_SEL_TRAP;
                    flush_id_c  = 1'b1;
                    bubble_ex_c = 1'b1;
                    state_d     = ST_RUN;
                end
                ST_DRAIN: begin
                    // EX holds only a bubble or the trap instruction, so a
                    // taken-branch indication here is meaningless.
                    stall_if_c  = 1'b1;
                    flush_id_c  = 1'b1;
                    bubble_ex_c = 1'b1;
                    if (drain_cnt_q == 3'd0) begin
                        state_d = ST_REDIRECT;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 3'd1;
                    end
                end
                default: begin
                    if (ex_br_taken) begin
                        // ID holds a wrong-path instruction: discard it along
                        // with any trap or hazard it would have raised.
                        pc_sel_c    = PC_SEL_BR;
                        flush_id_c  = 1'b1;
                        bubble_ex_c = 1'b1;
                    end else if (trap_in_id) begin
                        // The trap instruction moves on into EX; younger
                        // fetches are held and squashed until the redirect.
                        stall_if_c  = 1'b1;
                        flush_id_c  = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                        kind_d      = id_is_mret;
                    end else if (loaduse) begin
                        stall_if_c  = 1'b1;
                        stall_id_c  = 1'b1;
                        bubble_ex_c = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating stall counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_if && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Outputs read inactive for as long as reset is held, whatever the inputs.
    assign stall_if    = rst_n & stall_if_c;
    assign stall_id    = rst_n & stall_id_c;
    assign stall_ex    = rst_n & stall_ex_c;
    assign stall_mem   = rst_n & stall_mem_c;
    assign flush_id    = rst_n & flush_id_c;
    assign bubble_ex   = rst_n & bubble_ex_c;
    assign pc_sel      = rst_n ? pc_sel_c : PC_SEL_SEQ;
    assign stall_count = stall_count_q;

    assign dbg_o.state     = state_q;
    assign dbg_o.drain_cnt = drain_cnt_q;
    assign dbg_o.kind      = kind_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl. Control outputs are packed as
// {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, pc_sel[1:0]}.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam logic [7:0] E_NONE  = 8'b0000_0000;
    localparam logic [7:0] E_LU    = 8'b1100_0100;
    localparam logic [7:0] E_BR    = 8'b0000_1101;
    localparam logic [7:0] E_MW    = 8'b1111_0000;
    localparam logic [7:0] E_TRAPI = 8'b1000_1000;
    localparam logic [7:0] E_DRAIN = 8'b1000_1100;
    localparam logic [7:0] E_RMEPC = 8'b0000_1111;
    localparam logic [7:0] E_RTRAP = 8'b0000_1110;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_uses_rs1;
        logic       id_uses_rs2;
        logic       id_is_mret;
        logic       id_is_ecall;
        logic       ex_valid;
        logic       ex_is_load;
        logic [4:0] ex_rd;
        logic       ex_wr_reg_n;
        logic       ex_br_taken;
        logic       mem_req;
        logic       mem_ready;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, id_uses_rs1, id_uses_rs2, id_is_mret, id_is_ecall;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_valid, ex_is_load, ex_wr_reg_n, ex_br_taken, mem_req, mem_ready;
    logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex;
    logic [1:0] pc_sel;
    logic [31:0] stall_count;
    dbg_t       dbg;
    logic       s4_if, s4_id, s4_ex, s4_mem, s4_flush, s4_bubble;
    logic [1:0] s4_pc;
    logic [3:0] stall_count4;
    dbg_t       dbg4;

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_mret(id_is_mret), .id_is_ecall(id_is_ecall),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_wr_reg_n(ex_wr_reg_n), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .stall_mem(stall_mem), .flush_id(flush_id), .bubble_ex(bubble_ex),
        .pc_sel(pc_sel), .stall_count(stall_count), .dbg_o(dbg)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_mret(id_is_mret), .id_is_ecall(id_is_ecall),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_wr_reg_n(ex_wr_reg_n), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(s4_if), .stall_id(s4_id), .stall_ex(s4_ex),
        .stall_mem(s4_mem), .flush_id(s4_flush), .bubble_ex(s4_bubble),
        .pc_sel(s4_pc), .stall_count(stall_count4), .dbg_o(dbg4)
    );

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [31:0] exp_cnt;
    logic [3:0]  exp_cnt4;
    int          n_checks;
    int          n_fail;
    vec_t        vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    function automatic in_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mret,
                               input logic ecall, input logic exv, input logic ld,
                               input logic [4:0] rd, input logic wrn, input logic br,
                               input logic mreq, input logic mrdy);
        in_t r;
        r.id_valid = v;      r.id_rs1 = rs1;       r.id_rs2 = rs2;
        r.id_uses_rs1 = u1;  r.id_uses_rs2 = u2;
        r.id_is_mret = mret; r.id_is_ecall = ecall;
        r.ex_valid = exv;    r.ex_is_load = ld;    r.ex_rd = rd;
        r.ex_wr_reg_n = wrn; r.ex_br_taken = br;
        r.mem_req = mreq;    r.mem_ready = mrdy;
        return r;
    endfunction

    task automatic apply(input in_t v);
        id_valid = v.id_valid;       id_rs1 = v.id_rs1;         id_rs2 = v.id_rs2;
        id_uses_rs1 = v.id_uses_rs1; id_uses_rs2 = v.id_uses_rs2;
        id_is_mret = v.id_is_mret;   id_is_ecall = v.id_is_ecall;
        ex_valid = v.ex_valid;       ex_is_load = v.ex_is_load; ex_rd = v.ex_rd;
        ex_wr_reg_n = v.ex_wr_reg_n; ex_br_taken = v.ex_br_taken;
        mem_req = v.mem_req;         mem_ready = v.mem_ready;
    endtask

    task automatic compare(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, {24'd0, stall_if, stall_id, stall_ex, stall_mem,
                         flush_id, bubble_ex, pc_sel}, {24'd0, e});
            check({name, "_cnt"}, stall_count, exp_cnt);
            check({name, "_cnt4"}, {28'd0, stall_count4}, {28'd0, exp_cnt4});
            // Advance the counter models by what stall_if should be this cycle.
            if (e[7]) begin
                if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
                if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 1;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check just after.
    task automatic step(input string name, input in_t v, input logic [7:0] e);
        @(negedge clk);
        apply(v);
        exp_q.push_back(e);
        #2;
        compare(name);
    endtask

    // Pull reset while whatever state the DUT is in, with pipeline-stalling
    // inputs present, and check everything reads inactive immediately.
    task automatic do_reset(input string name, input in_t v);
        @(negedge clk);
        apply(v);
        rst_n = 1'b0;
        exp_cnt  = 32'd0;
        exp_cnt4 = 4'd0;
        exp_q.push_back(E_NONE);
        #2;
        compare(name);
        @(negedge clk);
        apply(mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0));
        rst_n = 1'b1;
    endtask

    in_t idle_in, mw_in, mret_in, ecall_in, br_in;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 32'd0;
        exp_cnt4 = 4'd0;
        idle_in  = mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0);
        mw_in    = mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0);
        mret_in  = mk(1,0,0,0,0,1,0,0,0,0,1,0,0,0);
        ecall_in = mk(1,0,0,0,0,0,1,0,0,0,1,0,0,0);
        br_in    = mk(0,0,0,0,0,0,0,0,0,0,1,1,0,0);

        // Reset state, with a memory wait present on the inputs.
        apply(mw_in);
        #2;
        exp_q.push_back(E_NONE);
        compare("reset_initial");
        @(negedge clk);
        apply(idle_in);
        rst_n = 1'b1;

        // ---------------- table-driven single-cycle RUN behaviour ----------------
        vecs[0]  = '{mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0), E_NONE};
        vecs[1]  = '{mk(1,5,6,1,1,0,0,1,1,5,0,0,0,0), E_LU};    // lw x5 ; add rs1=x5
        vecs[2]  = '{mk(1,0,6,1,1,0,0,1,1,0,0,0,0,0), E_NONE};  // load to x0
        vecs[3]  = '{mk(1,7,9,1,1,0,0,1,1,9,0,0,0,0), E_LU};    // rs2 match
        vecs[4]  = '{mk(1,9,3,0,1,0,0,1,1,9,0,0,0,0), E_NONE};  // rs1 match, unused
        vecs[5]  = '{mk(1,5,6,1,1,0,0,1,1,5,1,0,0,0), E_NONE};  // load writes no rd
        vecs[6]  = '{mk(0,5,6,1,1,0,0,1,1,5,0,0,0,0), E_NONE};  // ID empty
        vecs[7]  = '{mk(1,5,6,1,1,0,0,0,1,5,0,0,0,0), E_NONE};  // EX empty
        vecs[8]  = '{mk(1,5,6,1,1,0,0,1,0,5,0,0,0,0), E_NONE};  // not a load
        vecs[9]  = '{mk(1,5,6,1,1,0,0,1,1,5,0,1,0,0), E_BR};    // branch beats load-use
        vecs[10] = '{mk(1,5,6,1,1,0,0,1,1,5,0,1,1,0), E_MW};    // memwait beats all
        vecs[11] = '{mk(1,5,6,1,1,0,0,1,1,5,0,0,1,1), E_LU};    // memory completing
        vecs[12] = '{mk(1,0,0,0,0,1,0,1,0,0,1,1,0,0), E_BR};    // wrong-path mret
        vecs[13] = '{mk(1,31,2,1,0,0,0,1,1,31,0,0,0,0), E_LU};  // x31
        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
        end

        // Random fields under a memory wait: always a full freeze.
        for (int i = 0; i < 8; i++) begin
            in_t r;
            r = in_t'($urandom());
            r.mem_req = 1'b1;
            r.mem_ready = 1'b0;
            step($sformatf("rand_mw%0d", i), r, E_MW);
        end
        // Random ID fields with nothing in EX and no trap: no control action.
        for (int i = 0; i < 8; i++) begin
            in_t r;
            r = in_t'($urandom());
            r.ex_valid = 1'b0;
            r.ex_br_taken = 1'b0;
            r.id_is_mret = 1'b0;
            r.id_is_ecall = 1'b0;
            r.mem_ready = 1'b1;
            step($sformatf("rand_idle%0d", i), r, E_NONE);
        end
        // Branch held off by memwait, then taken once memory completes.
        step("br_defer_mw", mk(0,0,0,0,0,0,0,0,0,0,1,1,1,0), E_MW);
        step("br_defer_go", br_in, E_BR);

        // ---------------- mret: entry, 3 drain cycles, redirect to mepc ----------------
        step("mret_entry", mret_in, E_TRAPI);
        step("mret_d1_br_ignored", br_in, E_DRAIN);
        step("mret_d2", idle_in, E_DRAIN);
        step("mret_d3", idle_in, E_DRAIN);
        step("mret_redirect", idle_in, E_RMEPC);
        step("mret_run", idle_in, E_NONE);

        // ---------------- ecall beating load-use, memwait inside DRAIN ----------------
        step("ecall_mw_entry", mk(1,5,0,1,0,0,1,1,1,5,0,0,1,0), E_MW);
        step("ecall_entry", mk(1,5,0,1,0,0,1,1,1,5,0,0,0,0), E_TRAPI);
        step("ecall_d1", idle_in, E_DRAIN);
        for (int i = 0; i < 4; i++) step($sformatf("ecall_dmw%0d", i), mw_in, E_MW);
        step("ecall_d2", idle_in, E_DRAIN);
        step("ecall_d3", idle_in, E_DRAIN);
        step("ecall_redirect", idle_in, E_RTRAP);
        step("ecall_run", idle_in, E_NONE);

        // ---------------- memwait deferring the redirect ----------------
        step("mret2_entry", mret_in, E_TRAPI);
        for (int i = 0; i < 3; i++) step($sformatf("mret2_d%0d", i), idle_in, E_DRAIN);
        step("mret2_rmw0", mw_in, E_MW);
        step("mret2_rmw1", mw_in, E_MW);
        step("mret2_redirect", idle_in, E_RMEPC);
        step("mret2_run", idle_in, E_NONE);

        // ---------------- reset during REDIRECT and during DRAIN ----------------
        step("rst_r_entry", ecall_in, E_TRAPI);
        for (int i = 0; i < 3; i++) step($sformatf("rst_r_d%0d", i), idle_in, E_DRAIN);
        do_reset("rst_in_redirect", mw_in);
        step("rst_r_run0", idle_in, E_NONE);
        step("rst_r_run1", idle_in, E_NONE);

        step("rst_d_entry", mret_in, E_TRAPI);
        step("rst_d_d1", idle_in, E_DRAIN);
        do_reset("rst_in_drain", br_in);
        step("rst_d_run0", idle_in, E_NONE);
        step("rst_d_run1", idle_in, E_NONE);

        // ---------------- counter saturation (4-bit instance) ----------------
        for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i), mw_in, E_MW);
        step("sat_final", idle_in, E_NONE);
        check("sat_cnt4_value", {28'd0, stall_count4}, 32'd15);
        check("sat_cnt32_value", stall_count, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
